fft16_stage_sequencer: RTL
==========================

// Module: fft16_stage_sequencer
// PURPOSE
//  Control FSM and address generator for the in-place radix-2 DIT FFT core.
//  Drives one shared butterfly2 datapath through LOG2N stages of PTS/2 butterflies each.
//  For every butterfly it issues data-RAM read addresses and a twiddle-ROM index,
//  then issues the matching write-back addresses once the RAM and butterfly pipeline delay has elapsed.
//  It sits between the top-level start/done handshake and the data RAM, twiddle ROM and butterfly2.
// PARAMETERS
//  LOG2N   4  log2 of transform size; PTS = 1<<LOG2N points
//  STG_W   2  width of the stage counter, >= clog2(LOG2N)
//  RD_LAT  1  data-RAM and twiddle-ROM read latency in cycles (both are equal)
//  BF_LAT  1  butterfly2 input-to-output latency in cycles
// PORTS
//  i_clk       in   1           clock, rising edge
//  i_rst_n     in   1           asynchronous reset, active low
//  i_start     in   1           start request; sampled only in IDLE
//  o_busy      out  1           high while in RUN or FLUSH
//  o_done      out  1           single-cycle pulse when the last write has completed
//  o_stage     out  STG_W       current stage index, 0..LOG2N-1
//  o_rd_en     out  1           read strobe for the data RAM and twiddle ROM
//  o_rd_addr0  out  LOG2N       read address of the butterfly upper leg
//  o_rd_addr1  out  LOG2N       read address of the butterfly lower leg
//  o_tw_idx    out  LOG2N-1     twiddle-ROM index k of W_PTS^k
//  o_wr_en     out  1           write strobe for butterfly results
//  o_wr_addr0  out  LOG2N       write address for butterfly out0
//  o_wr_addr1  out  LOG2N       write address for butterfly out1
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters and delay line cleared. Reset may hit mid-run:
//   the sequencer aborts immediately, and no o_wr_en or o_done is produced after release.
//  PIPE = RD_LAT + BF_LAT.
//  FSM states and transitions:
//   IDLE  -> RUN on i_start; stage=0, bfly=0.
//   RUN   -> issues one butterfly per cycle for bfly 0..PTS/2-1; after the last, -> FLUSH.
//   FLUSH -> waits PIPE cycles so every write of the stage lands before the next stage reads (RAW guard);
//            then -> RUN with stage+1, or -> DONE if stage == LOG2N-1.
//   DONE  -> o_done=1 for exactly one cycle; -> IDLE.
//  i_start is ignored in RUN, FLUSH and DONE. If i_start is held high, a new run launches from the following IDLE.
//  Address generation for stage s, butterfly b (all outputs registered, valid when o_rd_en=1):
//   span = 1<<s; pos = b & (span-1); grp = b >> s
//   rd_addr0 = grp*2*span + pos; rd_addr1 = rd_addr0 + span
//   tw_idx = pos << (LOG2N-1-s)   (truncated to LOG2N-1 bits)
//  Data RAM input is in bit-reversed order; output is in natural order (not handled here).
//  Write path: {rd_en, rd_addr0, rd_addr1} pass through a PIPE-deep shift register to
//   {wr_en, wr_addr0, wr_addr1}. wr_en is therefore rd_en delayed by exactly PIPE cycles.
//  o_stage is held through each FLUSH and cleared in IDLE.
//  o_busy is 1 from the first RUN cycle through the last FLUSH cycle.
//  Cycle timing with defaults (edge 0 = i_start sampled in IDLE):
//   rd_en in cycles 1-8, 11-18, 21-28, 31-38
//   wr_en in cycles 3-10, 13-20, 23-30, 33-40
//   busy in cycles 1-40; done in cycle 41
//  Total cycles = LOG2N*(PTS/2+PIPE) + 1.
// TESTING
//  T1: defaults, pulse i_start -> stage 0 pairs (0,1),(2,3)..(14,15), tw_idx all 0;
//      o_done in cycle 41, exactly 40 busy cycles.
//  T2: stage 1 -> pairs (0,2),(1,3),(4,6),(5,7)..., tw 0,4,0,4...;
//      stage 3 -> pairs (0,8)..(7,15), tw 0,1..7.
//  T3: each wr_en pulse equals the rd_en pulse 2 cycles earlier with identical addresses;
//      the last write of stage s precedes the first read of stage s+1 by at least 1 cycle.
//  T4: i_start pulsed during RUN stage 2 -> ignored; one o_done only; i_start held high
//      -> second run starts in the cycle after the IDLE following o_done.
//  T5: i_rst_n asserted low at cycle 15 -> all outputs 0 asynchronously;
//      no wr_en or done after release; a fresh start then behaves as T1.
//  T6: RD_LAT=2, BF_LAT=3 -> write delay 5 cycles; FLUSH lasts 5 cycles; o_done in cycle 4*(8+5)+1 = 53.

Source files
------------

// File: rtl/fft16_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT.
// Issues read addresses and twiddle indices one butterfly per cycle, and
// replays the same addresses as write-backs after the RAM + butterfly delay.
module fft16_stage_sequencer #(
  parameter int LOG2N  = 4,
  parameter int STG_W  = 2,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [STG_W-1:0] o_stage,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr0,
  output logic [LOG2N-1:0] o_rd_addr1,
  output logic [LOG2N-2:0] o_tw_idx,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr0,
  output logic [LOG2N-1:0] o_wr_addr1
);

  localparam int PIPE = RD_LAT + BF_LAT;
  localparam int FL_W = (PIPE > 2) ? $clog2(PIPE) : 1;
  localparam logic [LOG2N-2:0] LAST_B   = {(LOG2N-1){1'b1}};
  localparam logic [FL_W-1:0]  LAST_FL  = FL_W'(PIPE-1);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2N-1);
  localparam logic [LOG2N-1:0] ONE      = {{(LOG2N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [LOG2N-1:0] a0;
    logic [LOG2N-1:0] a1;
  } addr_t;

  state_t           state, state_n;
  logic [STG_W-1:0] stage, stage_n;
  logic [LOG2N-2:0] bfly, bfly_n;
  logic [FL_W-1:0]  fl, fl_n;

  logic             issue;
  logic [LOG2N-1:0] b_ext, span, pos, grp, rd0_n, rd1_n;
  logic [LOG2N-2:0] tw_n;
  int               tw_sh;

  // vld_pipe[0]/apipe[0] are the read strobe/addresses; index PIPE is the write side
  logic [PIPE:0]    vld_pipe;
  addr_t            apipe [PIPE:0];
  logic [LOG2N-2:0] tw_q;
  logic             busy_q, done_q;

  // Next-state and counter logic
  always_comb begin
    state_n = state;
    stage_n = stage;
    bfly_n  = bfly;
    fl_n    = fl;
    case (state)
      IDLE: begin
        stage_n = '0;
        bfly_n  = '0;
        fl_n    = '0;
        if (i_start) state_n = RUN;
      end
      RUN: begin
        if (bfly == LAST_B) begin
          state_n = FLUSH;
          bfly_n  = '0;
          fl_n    = '0;
        end else begin
          bfly_n = bfly + 1'b1;
        end
      end
      FLUSH: begin
        // hold off the next stage until its predecessor's last write has landed
        if (fl == LAST_FL) begin
          fl_n = '0;
          if (stage == LAST_STG) begin
            state_n = DONE;
            stage_n = '0;
          end else begin
            state_n = RUN;
            stage_n = stage + 1'b1;
          end
        end else begin
          fl_n = fl + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        stage_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Butterfly addressing for the butterfly issued next cycle
  always_comb begin
    issue = (state_n == RUN);
    b_ext = {1'b0, bfly_n};
    span  = ONE << stage_n;
    pos   = b_ext & (span - ONE);
    grp   = b_ext >> stage_n;
    rd0_n = ((grp << stage_n) << 1) + pos;
    rd1_n = rd0_n + span;
    tw_sh = LOG2N - 1 - int'(stage_n);
    tw_n  = pos[LOG2N-2:0] << tw_sh;
  end

  // FSM state and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      stage <= '0;
      bfly  <= '0;
      fl    <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      bfly  <= bfly_n;
      fl    <= fl_n;
    end
  end

  // Registered outputs and the read-to-write delay line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i <= PIPE; i++) apipe[i] <= '0;
      tw_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE-1:0], issue};
      apipe[0] <= issue ? addr_t'{a0: rd0_n, a1: rd1_n} : '0;
      for (int i = 1; i <= PIPE; i++) apipe[i] <= apipe[i-1];
      tw_q   <= issue ? tw_n : '0;
      busy_q <= (state_n == RUN) || (state_n == FLUSH);
      done_q <= (state_n == DONE);
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_stage    = stage;
  assign o_rd_en    = vld_pipe[0];
  assign o_rd_addr0 = apipe[0].a0;
  assign o_rd_addr1 = apipe[0].a1;
  assign o_tw_idx   = tw_q;
  assign o_wr_en    = vld_pipe[PIPE];
  assign o_wr_addr0 = apipe[PIPE].a0;
  assign o_wr_addr1 = apipe[PIPE].a1;

endmodule
